// File: rtl/led_pkg.sv
// Shared types and the hex-to-segment encoder for the LED scan display.
package led_pkg;

    typedef logic [7:0] seg_t;

    typedef struct packed {
        logic       en;
        logic       dp;
        logic [3:0] hex;
    } digit_t;

    localparam seg_t SEG_OFF = 8'hFF;

    // Cathode-active form {dp,g,f,e,d,c,b,a}; the caller inverts for the pins.
    function automatic seg_t hex2seg(digit_t d);
        seg_t s;
        case (d.hex)
            4'h0:    s = 8'h3F;
            4'h1:    s = 8'h06;
            4'h2:    s = 8'h5B;
            4'h3:    s = 8'h4F;
            4'h4:    s = 8'h66;
            4'h5:    s = 8'h6D;
            4'h6:    s = 8'h7D;
            4'h7:    s = 8'h07;
            4'h8:    s = 8'h7F;
            4'h9:    s = 8'h6F;
            4'hA:    s = 8'h77;
            4'hB:    s = 8'h7C;
            4'hC:    s = 8'h39;
            4'hD:    s = 8'h5E;
            4'hE:    s = 8'h79;
            default: s = 8'h71;
        endcase
        s[7] = d.dp;
        return s;
    endfunction

endpackage

// File: rtl/led_scan_display_if.sv
// Digit write bus into the scan display: one word per cycle, no backpressure.
interface led_scan_display_if #(parameter int AW = 2);
    import led_pkg::*;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    digit_t        wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);

endinterface

// File: rtl/led_scan_timer.sv
// Slot prescaler and digit index; exposes next-cycle index/blank so the top can register outputs aligned.
module led_scan_timer #(
    parameter int N_DIGITS  = 4,
    parameter int DIV       = 10,
    parameter int BLANK_CYC = 2,
    parameter int AW        = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic [AW-1:0] idx_nxt_o,
    output logic          blank_nxt_o,
    output logic          frame_done_o
);

    localparam int PW = $clog2(DIV);

    logic [PW-1:0] p_q, p_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          step, last_slot;
    logic          frame_done_q;

    always_comb begin
        step      = (p_q == PW'(DIV - 1));
        last_slot = (idx_q == AW'(N_DIGITS - 1));
        p_d       = step ? '0 : p_q + 1'b1;
        idx_d     = idx_q;
        if (step) begin
            idx_d = last_slot ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            p_q          <= '0;
            idx_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            p_q          <= p_d;
            idx_q        <= idx_d;
            frame_done_q <= step && last_slot;
        end
    end

    assign idx_nxt_o    = idx_d;
    assign blank_nxt_o  = (p_d < PW'(BLANK_CYC));
    assign frame_done_o = frame_done_q;

endmodule

// File: rtl/led_scan_display.sv
// Multiplexed common-anode 7-segment driver with double-buffered digits.
// Optional brightness PWM on the anodes when LED_SCAN_DIMMING_EN is defined.
module led_scan_display
    import led_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int CLK_HZ    = 50_000_000,
    parameter int STEP_HZ   = 4_000,
    parameter int BLANK_CYC = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    led_scan_display_if.slave   wr,
`ifdef LED_SCAN_DIMMING_EN
    input  logic [3:0]          i_bright,
`endif
    output seg_t                o_seg,
    output logic [N_DIGITS-1:0] o_an,
    output logic                o_frame_done
);

    localparam int DIV = CLK_HZ / STEP_HZ;
    localparam int AW  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [AW-1:0] idx_nxt;
    logic          blank_nxt;
    logic          frame_done;

    led_scan_timer #(
        .N_DIGITS  (N_DIGITS),
        .DIV       (DIV),
        .BLANK_CYC (BLANK_CYC),
        .AW        (AW)
    ) u_timer (
        .clk_i        (i_clk),
        .rst_i        (i_rst),
        .idx_nxt_o    (idx_nxt),
        .blank_nxt_o  (blank_nxt),
        .frame_done_o (frame_done)
    );

    digit_t shadow_q [N_DIGITS];
    digit_t active_q [N_DIGITS];
    logic   addr_ok;

    generate
        if (N_DIGITS == (1 << AW)) begin : g_addr_full
            assign addr_ok = 1'b1;
        end else begin : g_addr_part
            assign addr_ok = (wr.wr_addr < AW'(N_DIGITS));
        end
    endgenerate

    // Copy lands on the same edge as a frame_done-cycle write, so it sees pre-write shadow.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            if (frame_done) begin
                for (int i = 0; i < N_DIGITS; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
            if (wr.wr_en && addr_ok) begin
                shadow_q[wr.wr_addr] <= wr.wr_data;
            end
        end
    end

    logic lit_on;
`ifdef LED_SCAN_DIMMING_EN
    logic [3:0] pwm_q, pwm_d;
    assign pwm_d  = pwm_q + 4'd1;
    assign lit_on = (pwm_d <= i_bright);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) pwm_q <= '0;
        else       pwm_q <= pwm_d;
    end
`else
    assign lit_on = 1'b1;
`endif

    digit_t                dig_nxt;
    seg_t                  seg_d, seg_q;
    logic [N_DIGITS-1:0]   an_d, an_q;

    always_comb begin
        dig_nxt = frame_done ? shadow_q[idx_nxt] : active_q[idx_nxt];
        seg_d   = SEG_OFF;
        an_d    = '1;
        if (!blank_nxt) begin
            an_d[idx_nxt] = ~lit_on;
            if (dig_nxt.en) begin
                seg_d = ~hex2seg(dig_nxt);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            seg_q <= SEG_OFF;
            an_q  <= '1;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign o_seg        = seg_q;
    assign o_an         = an_q;
    assign o_frame_done = frame_done;

endmodule
